// File: rtl/ddr3_dfi_pkg.sv
// ddr3_dfi_pkg: DFI command encodings, burst geometry and word-address helper.
package ddr3_dfi_pkg;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQ  = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    localparam int BURST_BEATS = 4;
    localparam int COL_SHIFT   = 3;
    localparam int NUM_BANKS   = 8;

    function automatic logic [26:0] burst_base(input logic [2:0] bank, input logic [14:0] row,
                                               input logic [6:0] col_blk);
        return {bank, row, col_blk, 2'b00};
    endfunction

endpackage

// File: rtl/ddr3_dfi_sram_ram.sv
// ddr3_dfi_sram_ram: synchronous 32-bit RAM, byte-enabled write port, read-before-write read port.
module ddr3_dfi_sram_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end

endmodule

// File: rtl/ddr3_dfi_sram.sv
// ddr3_dfi_sram: DFI-side DDR3 responder backed by a synchronous RAM (burst-8 x16 = 4 beats of 32 bits).
// Define DDR3_DFI_SRAM_PROTOCOL_CHECK_EN to add closed-bank, double-ACT and CKE-low command checks.
module ddr3_dfi_sram
    import ddr3_dfi_pkg::*;
#(
    parameter int DDR_READ_LATENCY = 4,
    parameter int MEM_ADDR_W       = 14,
    parameter int WR_QUEUE_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [14:0] dfi_address_i,
    input  logic [2:0]  dfi_bank_i,
    input  logic        dfi_cs_n_i,
    input  logic        dfi_ras_n_i,
    input  logic        dfi_cas_n_i,
    input  logic        dfi_we_n_i,
    input  logic        dfi_cke_i,
    input  logic        dfi_reset_n_i,
    input  logic        dfi_odt_i,
    input  logic [31:0] dfi_wrdata_i,
    input  logic        dfi_wrdata_en_i,
    input  logic [3:0]  dfi_wrdata_mask_i,
    input  logic        dfi_rddata_en_i,
    output logic [31:0] dfi_rddata_o,
    output logic        dfi_rddata_valid_o,
    output logic [1:0]  dfi_rddata_dnv_o,
    output logic        error_o
);

    localparam int QW = $clog2(WR_QUEUE_DEPTH);
    localparam int PD = DDR_READ_LATENCY - 1;

    logic [2:0]            cmd;
    logic                  cmd_v, is_act, is_pre, is_rd, is_wr;
    logic [14:0]           open_row [NUM_BANKS];
    logic [NUM_BANKS-1:0]  bank_open;
    logic [26:0]           cmd_word;
    logic [MEM_ADDR_W-1:0] cmd_base;
    logic [MEM_ADDR_W-1:0] wq [WR_QUEUE_DEPTH];
    logic [MEM_ADDR_W-1:0] wq_head;
    logic [QW-1:0]         wq_rd, wq_wr;
    logic [QW:0]           wq_cnt;
    logic [1:0]            beat;
    logic                  wq_full, push, beat_ok, pop, underflow;
    logic [PD-1:0]         rp_v;
    logic [MEM_ADDR_W-1:0] rp_a [PD];
    logic                  start, bg_active, rd_issue, overlap, rd_valid, proto_err;
    logic [1:0]            bg_beat;
    logic [MEM_ADDR_W-1:0] bg_base, rd_addr;
    logic [31:0]           ram_q;
    logic                  unused;

    assign cmd      = {dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i};
    assign cmd_v    = dfi_cke_i & dfi_reset_n_i & ~dfi_cs_n_i;
    assign is_act   = cmd_v && (cmd == CMD_ACT);
    assign is_pre   = cmd_v && (cmd == CMD_PRE);
    assign is_rd    = cmd_v && (cmd == CMD_RD);
    assign is_wr    = cmd_v && (cmd == CMD_WR);
    assign cmd_word = burst_base(dfi_bank_i, open_row[dfi_bank_i], dfi_address_i[9:COL_SHIFT]);
    assign cmd_base = cmd_word[MEM_ADDR_W-1:0];

    assign wq_full   = wq_cnt == (QW+1)'(WR_QUEUE_DEPTH);
    assign push      = is_wr & ~wq_full;
    assign beat_ok   = dfi_wrdata_en_i & dfi_reset_n_i & (wq_cnt != '0);
    assign underflow = dfi_wrdata_en_i & dfi_reset_n_i & (wq_cnt == '0);
    assign pop       = beat_ok & (beat == 2'd3);
    assign wq_head   = wq[wq_rd];

    assign start    = rp_v[PD-1];
    assign rd_issue = start | bg_active;
    assign overlap  = start & bg_active;
    assign rd_addr  = start ? rp_a[PD-1] : {bg_base[MEM_ADDR_W-1:2], bg_beat};

`ifdef DDR3_DFI_SRAM_PROTOCOL_CHECK_EN
    assign proto_err = ((is_rd | is_wr) & ~bank_open[dfi_bank_i]) | (is_act & bank_open[dfi_bank_i])
                     | (~dfi_cke_i & ~dfi_cs_n_i & dfi_reset_n_i);
`else
    assign proto_err = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (is_act) open_row[dfi_bank_i] <= dfi_address_i;
        if (push) wq[wq_wr] <= cmd_base;
        rp_a[0] <= cmd_base;
        for (int i = 1; i < PD; i++) rp_a[i] <= rp_a[i-1];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || !dfi_reset_n_i) begin
            bank_open <= '0;
            wq_rd     <= '0;
            wq_wr     <= '0;
            wq_cnt    <= '0;
            beat      <= '0;
            rp_v      <= '0;
            bg_active <= 1'b0;
            bg_beat   <= '0;
            bg_base   <= '0;
            rd_valid  <= 1'b0;
            if (!rst_i) error_o <= 1'b0;
        end else begin
            if (is_act) bank_open[dfi_bank_i] <= 1'b1;
            if (is_pre) bank_open <= dfi_address_i[10] ? '0 : bank_open & ~(NUM_BANKS'(1) << dfi_bank_i);
            if (push) wq_wr <= wq_wr + 1'b1;
            if (pop) wq_rd <= wq_rd + 1'b1;
            if (beat_ok) beat <= beat + 2'd1;
            wq_cnt <= wq_cnt + (QW+1)'(push) - (QW+1)'(pop);
            rp_v[0] <= is_rd;
            for (int i = 1; i < PD; i++) rp_v[i] <= rp_v[i-1];
            // A fresh burst always restarts the generator, truncating any burst in flight
            if (start) begin
                bg_active <= 1'b1;
                bg_beat   <= 2'd1;
                bg_base   <= rp_a[PD-1];
            end else if (bg_active) begin
                bg_beat   <= bg_beat + 2'd1;
                bg_active <= bg_beat != 2'd3;
            end
            rd_valid <= rd_issue;
            error_o  <= error_o | (is_wr & wq_full) | underflow | overlap | proto_err;
        end
    end

    ddr3_dfi_sram_ram #(.AW(MEM_ADDR_W)) u_ram (
        .clk   (clk_i),
        .we    (beat_ok),
        .be    (~dfi_wrdata_mask_i),
        .waddr ({wq_head[MEM_ADDR_W-1:2], beat}),
        .wdata (dfi_wrdata_i),
        .re    (rd_issue),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    assign dfi_rddata_o       = rd_valid ? ram_q : '0;
    assign dfi_rddata_valid_o = rd_valid;
    assign dfi_rddata_dnv_o   = '0;
    assign unused             = &{1'b0, dfi_odt_i, dfi_rddata_en_i, cmd_word};

endmodule

// File: tb/tb_ddr3_dfi_sram.sv
// tb_ddr3_dfi_sram: directed self-checking bench for ddr3_dfi_sram.
module tb_ddr3_dfi_sram;
    import ddr3_dfi_pkg::*;

`ifdef DDR3_DFI_SRAM_PROTOCOL_CHECK_EN
    localparam logic EXP_PROTO = 1'b1;
`else
    localparam logic EXP_PROTO = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0;
    logic [14:0] address = '0;
    logic [2:0]  bank = '0;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic        cke = 1'b1, reset_n = 1'b1, odt = 1'b0;
    logic [31:0] wrdata = '0;
    logic        wrdata_en = 1'b0;
    logic [3:0]  wrdata_mask = '0;
    logic        rddata_en = 1'b0;
    logic [31:0] rddata;
    logic        rddata_valid;
    logic [1:0]  rddata_dnv;
    logic        error;
    int          compared = 0, mismatched = 0;

    logic [3:0][31:0] d1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    logic [3:0][31:0] d3 = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    logic [3:0][31:0] dm = {4{32'hAABBCCDD}};
    logic [3:0][31:0] dn = {32'h9ABCDEF0, 32'h12345678, 32'h00000000, 32'h00000000};
    logic [3:0][31:0] em = {32'hAABBCCDD, 32'h12345678, 32'h00BB00DD, 32'hAA00CC00};
    logic [7:0][31:0] e8;
    logic [5:0][31:0] e6;

    ddr3_dfi_sram dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .dfi_address_i      (address),
        .dfi_bank_i         (bank),
        .dfi_cs_n_i         (cs_n),
        .dfi_ras_n_i        (ras_n),
        .dfi_cas_n_i        (cas_n),
        .dfi_we_n_i         (we_n),
        .dfi_cke_i          (cke),
        .dfi_reset_n_i      (reset_n),
        .dfi_odt_i          (odt),
        .dfi_wrdata_i       (wrdata),
        .dfi_wrdata_en_i    (wrdata_en),
        .dfi_wrdata_mask_i  (wrdata_mask),
        .dfi_rddata_en_i    (rddata_en),
        .dfi_rddata_o       (rddata),
        .dfi_rddata_valid_o (rddata_valid),
        .dfi_rddata_dnv_o   (rddata_dnv),
        .error_o            (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
        {ras_n, cas_n, we_n} = c;
        bank    = b;
        address = a;
        cs_n    = 1'b0;
        tick();
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = CMD_NOP;
    endtask

    task automatic wr_burst(input logic [2:0] b, input logic [14:0] col,
                            input logic [3:0][31:0] d, input logic [3:0][3:0] m);
        cmd(CMD_WR, b, col);
        for (int i = 0; i < 4; i++) begin
            wrdata_en   = 1'b1;
            wrdata      = d[i];
            wrdata_mask = m[i];
            tick();
        end
        wrdata_en   = 1'b0;
        wrdata_mask = '0;
    endtask

    task automatic rd_burst(input string tag, input logic [2:0] b, input logic [14:0] col,
                            input logic [3:0][31:0] e);
        cmd(CMD_RD, b, col);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            check({tag, "_valid"}, {31'd0, rddata_valid}, 32'd1);
            check({tag, "_data"}, rddata, e[i]);
            tick();
        end
        check({tag, "_end"}, {31'd0, rddata_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_data", rddata, 32'd0);
        check("rst_valid", {31'd0, rddata_valid}, 32'd0);
        check("rst_dnv", {30'd0, rddata_dnv}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b1;
        tick();

        cmd(CMD_ACT, 3'd2, 15'h15);
        wr_burst(3'd2, 15'h40, d1, '0);
        rd_burst("roundtrip", 3'd2, 15'h40, d1);
        check("roundtrip_err", {31'd0, error}, 32'd0);

        wr_burst(3'd2, 15'h48, dm, '0);
        wr_burst(3'd2, 15'h48, dn, {4'hF, 4'h0, 4'h5, 4'hA});
        rd_burst("mask", 3'd2, 15'h48, em);
        check("mask_err", {31'd0, error}, 32'd0);

        // RD spaced by 4: second burst follows the first with no gap
        e8 = {em, d1};
        cmd(CMD_RD, 3'd2, 15'h40);
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            check("gapless_valid", {31'd0, rddata_valid}, 32'd1);
            check("gapless_data", rddata, e8[i]);
            if (i == 0) cmd(CMD_RD, 3'd2, 15'h48);
            else tick();
        end
        check("gapless_end", {31'd0, rddata_valid}, 32'd0);
        check("gapless_err", {31'd0, error}, 32'd0);

        // RD spaced by 2: second burst truncates the first after two beats
        e6 = {em, d1[1], d1[0]};
        cmd(CMD_RD, 3'd2, 15'h40);
        tick();
        cmd(CMD_RD, 3'd2, 15'h48);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("overlap_valid", {31'd0, rddata_valid}, 32'd1);
            check("overlap_data", rddata, e6[i]);
            tick();
        end
        check("overlap_end", {31'd0, rddata_valid}, 32'd0);
        check("overlap_err", {31'd0, error}, 32'd1);

        do_reset();
        check("reset_clears_err", {31'd0, error}, 32'd0);
        cmd(CMD_ACT, 3'd2, 15'h15);
        repeat (4) cmd(CMD_WR, 3'd2, 15'h40);
        check("queue_full_no_err", {31'd0, error}, 32'd0);
        cmd(CMD_WR, 3'd2, 15'h40);
        check("queue_overflow_err", {31'd0, error}, 32'd1);

        do_reset();
        cmd(CMD_ACT, 3'd2, 15'h15);
        wrdata_en = 1'b1;
        wrdata    = 32'hDEADBEEF;
        tick();
        wrdata_en = 1'b0;
        check("underflow_err", {31'd0, error}, 32'd1);
        rd_burst("underflow_ram", 3'd2, 15'h40, d1);

        do_reset();
        cmd(CMD_ACT, 3'd2, 15'h15);
        cmd(CMD_PRE, 3'd0, 15'h400);
        cmd(CMD_RD, 3'd2, 15'h40);
        check("closed_bank_err", {31'd0, error}, {31'd0, EXP_PROTO});
        repeat (8) tick();

        do_reset();
        cmd(CMD_ACT, 3'd2, 15'h15);
        cmd(CMD_RD, 3'd2, 15'h40);
        repeat (3) tick();
        check("midburst_valid", {31'd0, rddata_valid}, 32'd1);
        check("midburst_data", rddata, 32'h11111111);
        rst = 1'b0;
        tick();
        check("midburst_rst_valid", {31'd0, rddata_valid}, 32'd0);
        check("midburst_rst_data", rddata, 32'd0);
        check("midburst_rst_err", {31'd0, error}, 32'd0);
        rst = 1'b1;
        repeat (6) tick();
        check("midburst_flushed", {31'd0, rddata_valid}, 32'd0);
        cmd(CMD_RD, 3'd2, 15'h40);
        check("banks_closed_err", {31'd0, error}, {31'd0, EXP_PROTO});
        repeat (8) tick();

        do_reset();
        cmd(CMD_ACT, 3'd5, 15'h7);
        wr_burst(3'd5, 15'h10, d3, '0);
        rd_burst("post_reset", 3'd5, 15'h10, d3);
        check("post_reset_err", {31'd0, error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
